// File: rtl/ar0134_pkg.sv
// Shared constants and FSM encoding for the AR0134 parallel receiver.
package ar0134_pkg;

  localparam int AR0134_DATA_W    = 10;
  localparam int AR0134_ACT_PIX   = 1282;
  localparam int AR0134_ACT_LINES = 722;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    IDLE  = 2'd1,
    FRAME = 2'd2
  } rxState_t;

endpackage

// File: rtl/ar0134_line_meas.sv
// Line/frame geometry measurement: saturating pixel and line counters,
// per-frame error accumulation and frame status registers.
module ar0134_line_meas #(
  parameter int CNT_W     = 12,
  parameter int FCNT_W    = 16,
  parameter int EXP_PIX   = 1282,
  parameter int EXP_LINES = 722
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              frameStart,
  input  logic              pixInc,
  input  logic              lineClose,
  input  logic              frameClose,
  output logic [CNT_W-1:0]  lastPixCnt,
  output logic [CNT_W-1:0]  frameLineCnt,
  output logic              errPix,
  output logic              errLine,
  output logic [FCNT_W-1:0] frameCnt
);

  localparam logic [CNT_W-1:0] EXP_PIX_C   = CNT_W'(EXP_PIX);
  localparam logic [CNT_W-1:0] EXP_LINES_C = CNT_W'(EXP_LINES);

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [CNT_W-1:0] pixCnt;
  logic [CNT_W-1:0] lineCnt;
  logic [CNT_W-1:0] lineCntNext;
  logic             errAcc;
  logic             errAccNext;

  // Next-values include a line closing this cycle, so a frame that ends on
  // the same edge as its last line reports that line too.
  always_comb begin
    lineCntNext = lineClose ? satInc(lineCnt) : lineCnt;
    errAccNext  = errAcc | (lineClose & (pixCnt != EXP_PIX_C));
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pixCnt       <= '0;
      lineCnt      <= '0;
      errAcc       <= 1'b0;
      lastPixCnt   <= '0;
      frameLineCnt <= '0;
      errPix       <= 1'b0;
      errLine      <= 1'b0;
      frameCnt     <= '0;
    end else if (frameStart) begin
      pixCnt  <= '0;
      lineCnt <= '0;
      errAcc  <= 1'b0;
    end else begin
      if (pixInc) begin
        pixCnt <= satInc(pixCnt);
      end
      if (lineClose) begin
        lastPixCnt <= pixCnt;
        pixCnt     <= '0;
      end
      lineCnt <= lineCntNext;
      errAcc  <= errAccNext;
      if (frameClose) begin
        frameLineCnt <= lineCntNext;
        errLine      <= (lineCntNext != EXP_LINES_C);
        errPix       <= errAccNext;
        frameCnt     <= frameCnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ar0134_rx_capture.sv
// AR0134 parallel-bus receiver: input sampling, one-pixel hold stage and
// capture FSM producing a pixel stream with SOF/EOL markers.
module ar0134_rx_capture
  import ar0134_pkg::*;
#(
  parameter int DATA_W    = AR0134_DATA_W,
  parameter int EXP_PIX   = AR0134_ACT_PIX,
  parameter int EXP_LINES = AR0134_ACT_LINES,
  parameter int CNT_W     = 12,
  parameter int FCNT_W    = 16
) (
  input  logic              iPixelClk,
  input  logic              iRstn,
  input  logic              iFV,
  input  logic              iLV,
  input  logic [DATA_W-1:0] iData,
  output logic              oValid,
  output logic [DATA_W-1:0] oData,
  output logic              oSOF,
  output logic              oEOL,
  output logic              oFrameDone,
  output logic [CNT_W-1:0]  oLineCnt,
  output logic [CNT_W-1:0]  oPixCnt,
  output logic              oErrPix,
  output logic              oErrLine,
  output logic [FCNT_W-1:0] oFrameCnt,
  output logic [1:0]        oDbgState
);

  // Output stream: no back-pressure. oValid is a one-cycle strobe; oData,
  // oSOF and oEOL are meaningful only in a cycle where oValid is high.

  logic              fvQ, lvQ, fvQq, lvQq;
  logic [DATA_W-1:0] dQ;
  logic [DATA_W-1:0] hold;
  logic              holdValid;
  logic              sofPending;
  rxState_t          state;

  logic fvRise, fvFall, lvFall;
  logic frameStart, frameClose, lineClose, pixInc;

  // Input registers run through reset so SYNC sees the real FV level.
  always_ff @(posedge iPixelClk) begin
    fvQ  <= iFV;
    lvQ  <= iLV;
    dQ   <= iData;
    fvQq <= fvQ;
    lvQq <= lvQ;
  end

  always_comb begin
    fvRise     = fvQ & ~fvQq;
    fvFall     = ~fvQ & fvQq;
    lvFall     = ~lvQ & lvQq;
    frameStart = (state == IDLE) & fvRise;
    frameClose = (state == FRAME) & fvFall;
    lineClose  = (state == FRAME) & holdValid & (fvFall | lvFall);
    pixInc     = (state == FRAME) & ~fvFall & lvQ;
  end

  always_ff @(posedge iPixelClk) begin
    if (!iRstn) begin
      state      <= SYNC;
      hold       <= '0;
      holdValid  <= 1'b0;
      sofPending <= 1'b0;
      oValid     <= 1'b0;
      oData      <= '0;
      oSOF       <= 1'b0;
      oEOL       <= 1'b0;
      oFrameDone <= 1'b0;
    end else begin
      oValid     <= 1'b0;
      oSOF       <= 1'b0;
      oEOL       <= 1'b0;
      oFrameDone <= 1'b0;
      case (state)
        SYNC: begin
          if (!fvQ) state <= IDLE;
        end
        IDLE: begin
          holdValid <= 1'b0;
          if (fvRise) begin
            state      <= FRAME;
            sofPending <= 1'b1;
          end
        end
        FRAME: begin
          // The pixel sitting in FV-low dQ during an FV fall is blanking and is dropped.
          if (lineClose) begin
            oValid     <= 1'b1;
            oData      <= hold;
            oEOL       <= 1'b1;
            oSOF       <= sofPending;
            sofPending <= 1'b0;
            holdValid  <= 1'b0;
          end else if (pixInc) begin
            hold      <= dQ;
            holdValid <= 1'b1;
            if (holdValid) begin
              oValid     <= 1'b1;
              oData      <= hold;
              oSOF       <= sofPending;
              sofPending <= 1'b0;
            end
          end
          if (fvFall) begin
            oFrameDone <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= SYNC;
      endcase
    end
  end

  assign oDbgState = state;

  ar0134_line_meas #(
    .CNT_W     (CNT_W),
    .FCNT_W    (FCNT_W),
    .EXP_PIX   (EXP_PIX),
    .EXP_LINES (EXP_LINES)
  ) uMeas (
    .clk          (iPixelClk),
    .rstn         (iRstn),
    .frameStart   (frameStart),
    .pixInc       (pixInc),
    .lineClose    (lineClose),
    .frameClose   (frameClose),
    .lastPixCnt   (oPixCnt),
    .frameLineCnt (oLineCnt),
    .errPix       (oErrPix),
    .errLine      (oErrLine),
    .frameCnt     (oFrameCnt)
  );

endmodule

// File: tb/tb_ar0134_rx_capture.sv
// Directed bench for ar0134_rx_capture with a small geometry (8x4).
module tb_ar0134_rx_capture;

  localparam int W = 44;  // {sample cycle[31:0], sof, eol, data[9:0]}

  logic        clk;
  logic        iRstn;
  logic        iFV;
  logic        iLV;
  logic [9:0]  iData;
  logic        oValid;
  logic [9:0]  oData;
  logic        oSOF;
  logic        oEOL;
  logic        oFrameDone;
  logic [11:0] oLineCnt;
  logic [11:0] oPixCnt;
  logic        oErrPix;
  logic        oErrLine;
  logic [15:0] oFrameCnt;
  logic [1:0]  oDbgState;

  ar0134_rx_capture #(
    .DATA_W    (10),
    .EXP_PIX   (8),
    .EXP_LINES (4),
    .CNT_W     (12),
    .FCNT_W    (16)
  ) dut (
    .iPixelClk  (clk),
    .iRstn      (iRstn),
    .iFV        (iFV),
    .iLV        (iLV),
    .iData      (iData),
    .oValid     (oValid),
    .oData      (oData),
    .oSOF       (oSOF),
    .oEOL       (oEOL),
    .oFrameDone (oFrameDone),
    .oLineCnt   (oLineCnt),
    .oPixCnt    (oPixCnt),
    .oErrPix    (oErrPix),
    .oErrLine   (oErrLine),
    .oFrameCnt  (oFrameCnt),
    .oDbgState  (oDbgState)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // scoreboard state
  logic [W-1:0] expQ[$];
  int           checks     = 0;
  int           failures   = 0;
  int           doneCnt    = 0;
  int           sofCnt     = 0;
  int           doneCyc    = -1;
  int           lastEolCyc = -2;
  logic [9:0]   dataNext   = 10'd0;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // monitor: outputs sampled on the falling edge
  always @(negedge clk) begin
    if (oValid) begin
      if (expQ.size() == 0) begin
        checkVal("spurious_valid", 32'(oValid), 32'd0);
      end else begin
        logic [W-1:0] e;
        e = expQ.pop_front();
        checkVal("pix_data", 32'(oData), 32'(e[9:0]));
        checkVal("pix_eol", 32'(oEOL), 32'(e[10]));
        checkVal("pix_sof", 32'(oSOF), 32'(e[11]));
        checkVal("pix_latency", 32'(cyc), e[43:12] + 32'd2);
      end
      if (oSOF) sofCnt++;
      if (oEOL) lastEolCyc = cyc;
    end
    if (oFrameDone) begin
      doneCnt++;
      doneCyc = cyc;
    end
  end

  // driver: inputs change on the falling edge and are sampled at the next rising edge
  task automatic driveCycle(input logic fv, input logic lv, input logic [9:0] d,
                            input bit expPix, input bit sof, input bit eol);
    iFV   = fv;
    iLV   = lv;
    iData = d;
    if (expPix) expQ.push_back({32'(cyc + 1), sof, eol, d});
    @(negedge clk);
  endtask

  task automatic sendFrame(input int l0, input int l1, input int l2, input int l3,
                           input int truncLine, input int truncPix, input int vBlank);
    int lens[4];
    bit sof;
    bit trunc;
    lens = '{l0, l1, l2, l3};
    sof  = 1'b1;
    repeat (2) driveCycle(1'b1, 1'b0, 10'h3AA, 1'b0, 1'b0, 1'b0);
    for (int l = 0; l < 4; l++) begin
      for (int p = 0; p < lens[l]; p++) begin
        trunc = (l == truncLine) && (p == truncPix);
        driveCycle(1'b1, 1'b1, dataNext, 1'b1, sof, (p == lens[l] - 1) || trunc);
        sof      = 1'b0;
        dataNext = dataNext + 10'd1;
        if (trunc) begin
          driveCycle(1'b0, 1'b1, 10'h155, 1'b0, 1'b0, 1'b0);
          repeat (vBlank) driveCycle(1'b0, 1'b0, 10'h2AA, 1'b0, 1'b0, 1'b0);
          return;
        end
      end
      repeat (4) driveCycle(1'b1, 1'b0, 10'h3AA, 1'b0, 1'b0, 1'b0);
    end
    repeat (vBlank) driveCycle(1'b0, 1'b0, 10'h2AA, 1'b0, 1'b0, 1'b0);
  endtask

  int doneBase;
  int sofBase;
  logic [11:0] savLine;
  logic [11:0] savPix;
  logic [15:0] savFrame;

  initial begin
    iRstn = 1'b0;
    iFV   = 1'b0;
    iLV   = 1'b0;
    iData = 10'd0;
    repeat (3) @(negedge clk);
    checkVal("rst_valid", 32'(oValid), 32'd0);
    checkVal("rst_framecnt", 32'(oFrameCnt), 32'd0);
    checkVal("rst_linecnt", 32'(oLineCnt), 32'd0);
    checkVal("rst_state", 32'(oDbgState), 32'd0);
    iRstn = 1'b1;
    repeat (3) driveCycle(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0);
    checkVal("sync_to_idle", 32'(oDbgState), 32'd1);

    // 1: nominal 4x8 frame, data ramp 0x000..0x01F
    dataNext = 10'd0;
    sendFrame(8, 8, 8, 8, -1, -1, 6);
    checkVal("t1_beats_left", 32'(expQ.size()), 32'd0);
    checkVal("t1_done", 32'(doneCnt), 32'd1);
    checkVal("t1_sof", 32'(sofCnt), 32'd1);
    checkVal("t1_linecnt", 32'(oLineCnt), 32'd4);
    checkVal("t1_pixcnt", 32'(oPixCnt), 32'd8);
    checkVal("t1_errpix", 32'(oErrPix), 32'd0);
    checkVal("t1_errline", 32'(oErrLine), 32'd0);
    checkVal("t1_framecnt", 32'(oFrameCnt), 32'd1);

    // 2: short second line, then a clean frame
    sendFrame(8, 6, 8, 8, -1, -1, 6);
    checkVal("t2_beats_left", 32'(expQ.size()), 32'd0);
    checkVal("t2_errpix", 32'(oErrPix), 32'd1);
    checkVal("t2_errline", 32'(oErrLine), 32'd0);
    checkVal("t2_linecnt", 32'(oLineCnt), 32'd4);
    checkVal("t2_framecnt", 32'(oFrameCnt), 32'd2);
    sendFrame(8, 8, 8, 8, -1, -1, 6);
    checkVal("t2_clean_errpix", 32'(oErrPix), 32'd0);
    checkVal("t2_clean_framecnt", 32'(oFrameCnt), 32'd3);

    // 3: FV falls with LV high after pixel 5 of line 3
    sendFrame(8, 8, 8, 8, 2, 4, 6);
    checkVal("t3_beats_left", 32'(expQ.size()), 32'd0);
    checkVal("t3_eol_with_done", 32'(doneCyc), 32'(lastEolCyc));
    checkVal("t3_linecnt", 32'(oLineCnt), 32'd3);
    checkVal("t3_pixcnt", 32'(oPixCnt), 32'd5);
    checkVal("t3_errline", 32'(oErrLine), 32'd1);
    checkVal("t3_errpix", 32'(oErrPix), 32'd1);
    checkVal("t3_framecnt", 32'(oFrameCnt), 32'd4);

    // 5: LV pulse with FV low is ignored
    doneBase = doneCnt;
    savLine  = oLineCnt;
    savPix   = oPixCnt;
    savFrame = oFrameCnt;
    for (int i = 0; i < 10; i++) driveCycle(1'b0, 1'b1, 10'(i + 100), 1'b0, 1'b0, 1'b0);
    repeat (4) driveCycle(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0);
    checkVal("t5_done", 32'(doneCnt), 32'(doneBase));
    checkVal("t5_linecnt", 32'(oLineCnt), 32'(savLine));
    checkVal("t5_pixcnt", 32'(oPixCnt), 32'(savPix));
    checkVal("t5_framecnt", 32'(oFrameCnt), 32'(savFrame));

    // 4: reset during line 2; the rest of that frame must not appear
    repeat (2) driveCycle(1'b1, 1'b0, 10'h3AA, 1'b0, 1'b0, 1'b0);
    for (int p = 0; p < 8; p++) begin
      driveCycle(1'b1, 1'b1, dataNext, 1'b1, p == 0, p == 7);
      dataNext = dataNext + 10'd1;
    end
    repeat (4) driveCycle(1'b1, 1'b0, 10'h3AA, 1'b0, 1'b0, 1'b0);
    doneBase = doneCnt;
    iRstn = 1'b0;
    driveCycle(1'b1, 1'b1, 10'h111, 1'b0, 1'b0, 1'b0);
    checkVal("t4_rst_valid", 32'(oValid), 32'd0);
    checkVal("t4_rst_framecnt", 32'(oFrameCnt), 32'd0);
    checkVal("t4_rst_linecnt", 32'(oLineCnt), 32'd0);
    checkVal("t4_rst_pixcnt", 32'(oPixCnt), 32'd0);
    checkVal("t4_rst_errs", 32'({oErrPix, oErrLine, oFrameDone}), 32'd0);
    driveCycle(1'b1, 1'b1, 10'h112, 1'b0, 1'b0, 1'b0);
    iRstn = 1'b1;
    for (int p = 0; p < 6; p++) driveCycle(1'b1, 1'b1, 10'(p + 300), 1'b0, 1'b0, 1'b0);
    for (int l = 0; l < 2; l++) begin
      repeat (4) driveCycle(1'b1, 1'b0, 10'h3AA, 1'b0, 1'b0, 1'b0);
      for (int p = 0; p < 8; p++) driveCycle(1'b1, 1'b1, 10'(p + 400), 1'b0, 1'b0, 1'b0);
    end
    repeat (6) driveCycle(1'b0, 1'b0, 10'h2AA, 1'b0, 1'b0, 1'b0);
    checkVal("t4_no_done", 32'(doneCnt), 32'(doneBase));
    checkVal("t4_beats_left", 32'(expQ.size()), 32'd0);
    sendFrame(8, 8, 8, 8, -1, -1, 6);
    checkVal("t4_next_framecnt", 32'(oFrameCnt), 32'd1);
    checkVal("t4_next_linecnt", 32'(oLineCnt), 32'd4);
    checkVal("t4_next_errs", 32'({oErrPix, oErrLine}), 32'd0);
    checkVal("t4_next_beats_left", 32'(expQ.size()), 32'd0);

    // 6: three frames back to back with 5-cycle vertical blank
    iRstn = 1'b0;
    repeat (2) driveCycle(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0);
    iRstn = 1'b1;
    repeat (3) driveCycle(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0);
    doneBase = doneCnt;
    sofBase  = sofCnt;
    repeat (3) sendFrame(8, 8, 8, 8, -1, -1, 5);
    checkVal("t6_done", 32'(doneCnt - doneBase), 32'd3);
    checkVal("t6_sof", 32'(sofCnt - sofBase), 32'd3);
    checkVal("t6_framecnt", 32'(oFrameCnt), 32'd3);
    checkVal("t6_beats_left", 32'(expQ.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
